// File: rtl/gb80_mcycle_sequencer.sv
`default_nettype none
// ============================================================================
// gb80_mcycle_sequencer : T-state / M-cycle timing for fetch, execute, HALT
//                         and interrupt-acknowledge sequences
// Revision : 1.0
// ============================================================================
module gb80_mcycle_sequencer #(
   parameter int MC_WIDTH        = 3,
   parameter int MAX_MCYCLES     = 6,
   parameter int INT_ACK_MCYCLES = 5,
   parameter bit WAIT_EN         = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [MC_WIDTH-1:0] i_mcycles,
   input  logic [1:0]          i_mc_type,
   input  logic                i_mc_pc_inc,
   input  logic                i_halt,
   input  logic                i_int_req,
   input  logic                i_ime,
   input  logic                i_mem_ready,
   output logic [1:0]          o_tstate,
   output logic [MC_WIDTH-1:0] o_mcycle,
   output logic                o_mem_rd,
   output logic                o_mem_wr,
   output logic                o_ir_we,
   output logic                o_pc_inc,
   output logic                o_instr_done,
   output logic                o_int_ack,
   output logic                o_halted
);

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_HALT   = 3'd3,
      S_INTACK = 3'd4
   } state_t;

   localparam logic [MC_WIDTH-1:0] MC_ONE      = MC_WIDTH'(1);
   localparam logic [MC_WIDTH-1:0] MC_MAX      = MC_WIDTH'(MAX_MCYCLES);
   localparam logic [MC_WIDTH-1:0] MC_ACK_LAST = MC_WIDTH'(INT_ACK_MCYCLES);

   state_t              state_q, state_d;
   logic [1:0]          tstate_q, tstate_d;
   logic [MC_WIDTH-1:0] mcycle_q, mcycle_d;
   logic [MC_WIDTH-1:0] count_q, count_d;
   logic                ir_we_q, done_q, int_ack_q, halted_q;
   logic                w_rd_cyc, w_wr_cyc, w_wait, w_end;

   always_comb begin
      state_d  = state_q;
      tstate_d = tstate_q + 2'd1;
      mcycle_d = mcycle_q;
      count_d  = count_q;
      w_end    = 1'b0;
      w_rd_cyc = (state_q == S_FETCH) || ((state_q == S_EXEC) && (i_mc_type == 2'b01));
      w_wr_cyc = (state_q == S_EXEC) && (i_mc_type == 2'b10);
      w_wait   = WAIT_EN && (tstate_q == 2'd1) && (w_rd_cyc || w_wr_cyc) && !i_mem_ready;

      case (state_q)
         S_RST: begin
            state_d  = S_FETCH;
            tstate_d = 2'd0;
            mcycle_d = MC_ONE;
         end
         S_FETCH: begin
            // Out-of-range lengths from the decoder collapse to a single fetch cycle
            if (tstate_q == 2'd2)
               count_d = ((i_mcycles == '0) || (i_mcycles > MC_MAX)) ? MC_ONE : i_mcycles;
            if (tstate_q == 2'd3) begin
               if (count_q == MC_ONE) begin
                  w_end = 1'b1;
               end else begin
                  state_d  = S_EXEC;
                  mcycle_d = mcycle_q + MC_ONE;
               end
            end
         end
         S_EXEC: begin
            if (tstate_q == 2'd3) begin
               if (mcycle_q >= count_q) w_end = 1'b1;
               else                     mcycle_d = mcycle_q + MC_ONE;
            end
         end
         S_HALT: begin
            if ((tstate_q == 2'd3) && i_int_req)
               state_d = i_ime ? S_INTACK : S_FETCH;
         end
         S_INTACK: begin
            if (tstate_q == 2'd3) begin
               if (mcycle_q >= MC_ACK_LAST) begin
                  state_d  = S_FETCH;
                  mcycle_d = MC_ONE;
               end else begin
                  mcycle_d = mcycle_q + MC_ONE;
               end
            end
         end
         default: state_d = S_RST;
      endcase

      if (w_end) begin
         mcycle_d = MC_ONE;
         if (i_halt)                     state_d = S_HALT;
         else if (i_int_req && i_ime)    state_d = S_INTACK;
         else                            state_d = S_FETCH;
      end
      if (w_wait) tstate_d = tstate_q;
   end

   // Pulse outputs are registered from the next-state decode so they line up with the T-state
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_RST;
         tstate_q  <= 2'd0;
         mcycle_q  <= MC_ONE;
         count_q   <= MC_ONE;
         ir_we_q   <= 1'b0;
         done_q    <= 1'b0;
         int_ack_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tstate_q  <= tstate_d;
         mcycle_q  <= mcycle_d;
         count_q   <= count_d;
         ir_we_q   <= (state_d == S_FETCH) && (tstate_d == 2'd2);
         done_q    <= (tstate_d == 2'd3) &&
                      (((state_d == S_FETCH) && (count_d == MC_ONE)) ||
                       ((state_d == S_EXEC) && (mcycle_d >= count_d)));
         int_ack_q <= (state_d == S_INTACK) && (mcycle_d == MC_ONE) && (tstate_d == 2'd3);
         halted_q  <= (state_d == S_HALT);
      end
   end

   // Memory strobes follow the type of the M-cycle in progress, decoded from registered T/M state
   assign o_mem_rd     = w_rd_cyc && !tstate_q[1];
   assign o_mem_wr     = w_wr_cyc && ((tstate_q == 2'd1) || (tstate_q == 2'd2));
   assign o_pc_inc     = (tstate_q == 2'd3) && w_rd_cyc && ((state_q == S_FETCH) || i_mc_pc_inc);
   assign o_tstate     = tstate_q;
   assign o_mcycle     = mcycle_q;
   assign o_ir_we      = ir_we_q;
   assign o_instr_done = done_q;
   assign o_int_ack    = int_ack_q;
   assign o_halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_gb80_mcycle_sequencer.sv
`default_nettype none
// ============================================================================
// tb_gb80_mcycle_sequencer : scenario bench with a cycle-level expected trace
// Revision : 1.0
// ============================================================================
module tb_gb80_mcycle_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] mcycles = '0;
   logic [1:0] mc_type = '0;
   logic       pci_in = 1'b0, halt = 1'b0, int_req = 1'b0, ime = 1'b0, ready = 1'b1;
   logic [1:0] o_tstate;
   logic [2:0] o_mcycle;
   logic       o_mem_rd, o_mem_wr, o_ir_we, o_pc_inc, o_instr_done, o_int_ack, o_halted;
   logic [11:0] obs;

   always #5 clk = ~clk;

   gb80_mcycle_sequencer dut (
      .i_clk(clk), .i_reset(rst), .i_mcycles(mcycles), .i_mc_type(mc_type),
      .i_mc_pc_inc(pci_in), .i_halt(halt), .i_int_req(int_req), .i_ime(ime),
      .i_mem_ready(ready), .o_tstate(o_tstate), .o_mcycle(o_mcycle),
      .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_ir_we(o_ir_we), .o_pc_inc(o_pc_inc),
      .o_instr_done(o_instr_done), .o_int_ack(o_int_ack), .o_halted(o_halted)
   );

   assign obs = {o_tstate, o_mcycle, o_mem_rd, o_mem_wr, o_ir_we, o_pc_inc,
                 o_instr_done, o_int_ack, o_halted};

   // One clock of the reference trace: inputs to apply and outputs to expect
   typedef struct packed {
      logic [2:0]  mcyc;
      logic [1:0]  typ;
      logic        pci, hlt, irq, ime, rdy;
      logic [11:0] exp;
   } cyc_t;

   cyc_t sched[$];
   int   total = 0;
   int   bad   = 0;
   int   g_typ[8];
   bit   g_pci[8];
   int   g_wait[8];

   function automatic logic [11:0] pk(int t, int m, bit rd, bit wr, bit ir, bit pc,
                                      bit dn, bit ak, bit hl);
      logic [1:0] tt;
      logic [2:0] mm;
      tt = t[1:0];
      mm = m[2:0];
      return {tt, mm, rd, wr, ir, pc, dn, ak, hl};
   endfunction

   function automatic cyc_t rnd_in();
      cyc_t c;
      c.mcyc = 3'($urandom);
      c.typ  = 2'($urandom);
      c.pci  = 1'($urandom);
      c.hlt  = 1'($urandom);
      c.irq  = 1'($urandom);
      c.ime  = 1'($urandom);
      c.rdy  = 1'($urandom);
      c.exp  = '0;
      return c;
   endfunction

   task automatic drive(input cyc_t c);
      mcycles = c.mcyc; mc_type = c.typ; pci_in = c.pci;
      halt = c.hlt; int_req = c.irq; ime = c.ime; ready = c.rdy;
   endtask

   task automatic clear_prog();
      for (int m = 0; m < 8; m++) begin
         g_typ[m] = 0; g_pci[m] = 0; g_wait[m] = 0;
      end
   endtask

   // Instruction model: M1 fetch then M2..Mn per g_typ; returns 0 fetch, 1 halt, 2 int-ack
   task automatic model_instr(input int raw_n, input bit e_halt, input bit e_irq,
                              input bit e_ime, output int nxt);
      int n;
      cyc_t c;
      bit rd, wr, mem, last;
      n = (raw_n < 1 || raw_n > 6) ? 1 : raw_n;
      for (int m = 1; m <= n; m++) begin
         rd  = (m == 1) || (g_typ[m] == 1);
         wr  = (m > 1) && (g_typ[m] == 2);
         mem = rd || wr;
         for (int t = 0; t < 4; t++) begin
            int reps;
            reps = (t == 1 && mem) ? g_wait[m] + 1 : 1;
            for (int r = 0; r < reps; r++) begin
               c = rnd_in();
               if (m > 1) c.typ = 2'(g_typ[m]);
               if (m == 1 && t == 2) c.mcyc = 3'(raw_n);
               if (m > 1 && t == 3) c.pci = g_pci[m];
               if (t == 1 && mem) c.rdy = (r == reps - 1);
               last = (m == n) && (t == 3);
               if (last) begin
                  c.hlt = e_halt; c.irq = e_irq; c.ime = e_ime;
               end
               c.exp = pk(t, m, rd && t <= 1, wr && (t == 1 || t == 2), m == 1 && t == 2,
                          t == 3 && (m == 1 || (rd && g_pci[m])), last, 1'b0, 1'b0);
               sched.push_back(c);
            end
         end
      end
      nxt = e_halt ? 1 : ((e_irq && e_ime) ? 2 : 0);
   endtask

   task automatic model_halt(input int wakes, input bit w_ime, output int nxt);
      cyc_t c;
      for (int k = 1; k <= wakes; k++)
         for (int t = 0; t < 4; t++) begin
            c = rnd_in();
            if (t == 3) c.irq = (k == wakes);
            if (t == 3 && k == wakes) c.ime = w_ime;
            c.exp = pk(t, 1, 0, 0, 0, 0, 0, 0, 1'b1);
            sched.push_back(c);
         end
      nxt = w_ime ? 2 : 0;
   endtask

   task automatic model_intack();
      cyc_t c;
      for (int m = 1; m <= 5; m++)
         for (int t = 0; t < 4; t++) begin
            c = rnd_in();
            c.exp = pk(t, m, 0, 0, 0, 0, 0, m == 1 && t == 3, 1'b0);
            sched.push_back(c);
         end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive(rnd_in());
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(rnd_in());
         @(negedge clk);
         total++;
         if (obs !== pk(0, 1, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset[%0d]: got %h want %h", i, obs, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      int nxt;
      apply_reset();
      clear_prog();
      model_instr(1, 0, 0, 0, nxt);
      model_instr(1, 0, 0, 0, nxt);
      foreach (sched[i]) begin
         @(posedge clk); #1; drive(sched[i]);
         @(negedge clk);
         total++;
         if (obs !== sched[i].exp) begin
            bad++; $display("FAIL single c%0d: got %h want %h", i, obs, sched[i].exp);
         end
      end
      sched.delete();
   endtask

   task automatic test_three_mcycle(input int wait_clks, input string nm);
      int nxt;
      apply_reset();
      clear_prog();
      g_typ[2] = 1; g_pci[2] = 1; g_wait[2] = wait_clks;
      g_typ[3] = 2;
      model_instr(3, 0, 0, 0, nxt);
      model_instr(1, 0, 0, 0, nxt);
      foreach (sched[i]) begin
         @(posedge clk); #1; drive(sched[i]);
         @(negedge clk);
         total++;
         if (obs !== sched[i].exp) begin
            bad++; $display("FAIL %s c%0d: got %h want %h", nm, i, obs, sched[i].exp);
         end
      end
      sched.delete();
   endtask

   task automatic test_halt();
      int nxt;
      apply_reset();
      clear_prog();
      model_instr(1, 1, 0, 0, nxt);
      model_halt(2, 0, nxt);
      model_instr(2, 0, 0, 0, nxt);
      foreach (sched[i]) begin
         @(posedge clk); #1; drive(sched[i]);
         @(negedge clk);
         total++;
         if (obs !== sched[i].exp) begin
            bad++; $display("FAIL halt c%0d: got %h want %h", i, obs, sched[i].exp);
         end
      end
      sched.delete();
   endtask

   task automatic test_intack();
      int nxt;
      apply_reset();
      clear_prog();
      model_instr(2, 0, 1, 1, nxt);
      model_intack();
      model_instr(1, 1, 0, 0, nxt);
      model_halt(1, 1, nxt);
      model_intack();
      model_instr(1, 0, 0, 0, nxt);
      foreach (sched[i]) begin
         @(posedge clk); #1; drive(sched[i]);
         @(negedge clk);
         total++;
         if (obs !== sched[i].exp) begin
            bad++; $display("FAIL intack c%0d: got %h want %h", i, obs, sched[i].exp);
         end
      end
      sched.delete();
   endtask

   task automatic test_reset_mid();
      int nxt;
      apply_reset();
      clear_prog();
      g_typ[2] = 1; g_typ[3] = 2;
      model_instr(3, 0, 0, 0, nxt);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1; drive(sched[i]);
         @(negedge clk);
         total++;
         if (obs !== sched[i].exp) begin
            bad++; $display("FAIL rstmid pre c%0d: got %h want %h", i, obs, sched[i].exp);
         end
      end
      sched.delete();
      #1 rst = 1'b1;
      #1;
      total++;
      if (obs !== pk(0, 1, 0, 0, 0, 0, 0, 0, 0)) begin
         bad++; $display("FAIL rstmid async: got %h want %h", obs, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (obs !== pk(0, 1, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL rstmid hold%0d: got %h want %h", i, obs, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
         end
      end
      rst = 1'b0;
      clear_prog();
      model_instr(1, 0, 0, 0, nxt);
      foreach (sched[i]) begin
         @(posedge clk); #1; drive(sched[i]);
         @(negedge clk);
         total++;
         if (obs !== sched[i].exp) begin
            bad++; $display("FAIL rstmid post c%0d: got %h want %h", i, obs, sched[i].exp);
         end
      end
      sched.delete();
   endtask

   task automatic test_random();
      int nxt;
      apply_reset();
      for (int k = 0; k < 40; k++) begin
         for (int m = 0; m < 8; m++) begin
            g_typ[m]  = int'($urandom_range(0, 3));
            g_pci[m]  = 1'($urandom);
            g_wait[m] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         end
         model_instr(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                     1'($urandom), 1'($urandom), nxt);
         if (nxt == 1) model_halt(int'($urandom_range(1, 3)), 1'($urandom), nxt);
         if (nxt == 2) model_intack();
      end
      foreach (sched[i]) begin
         @(posedge clk); #1; drive(sched[i]);
         @(negedge clk);
         total++;
         if (obs !== sched[i].exp) begin
            bad++; $display("FAIL random c%0d: got %h want %h", i, obs, sched[i].exp);
         end
      end
      sched.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_three_mcycle(0, "three_mc");
      test_three_mcycle(3, "wait");
      test_halt();
      test_intack();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
